dht11_scheduler: RTL and testbench
==================================

Name: dht11_scheduler

Overview:
- Sequences the DHT11 interface block. Decides when a measurement is triggered and shares that trigger between a periodic timer and a manual requester.
- Enforces the sensor's minimum rest interval between transactions.
- Watchdogs each transaction with a timeout and resets the interface on a hang.
- Sits between the top-level control and the interface's medir_dht11 / pronto_medida handshake.

Parameters:
PERIODO, 100000000, clock cycles between periodic requests (2 s at 50 MHz)
INTERVALO_MIN, 50000000, minimum idle cycles after any transaction ends
TIMEOUT, 25000000, cycles allowed from trigger to pronto_medida
MAX_TENTATIVAS, 3, retries after a timeout (used only with the optional feature)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
habilita  in  1  enables the periodic timer
medir_manual  in  1  manual request, level sampled each cycle
pronto_medida  in  1  one-cycle completion pulse from the interface
medir_dht11  out  1  one-cycle trigger to the interface
reset_interface  out  1  one-cycle reset pulse to the interface on timeout
ocupado  out  1  high in any state except OCIOSO
pronto  out  1  one-cycle pulse: new valid measurement
erro_timeout  out  1  sticky error, cleared by next success
contagem_falhas  out  8  saturating timeout count
fonte_ultima  out  1  source of the current/last transaction: 0 periodic, 1 manual
db_estado  out  3  current state encoding

Behaviour:
- Reset (async): state OCIOSO; all outputs 0; counters 0; pending flags 0.
- Periodic timer:
  - Counts while habilita=1; held at 0 while habilita=0.
  - At count PERIODO-1: sets pend_per and wraps to 0. Runs in every state.
- Manual request: medir_manual=1 in any cycle sets pend_man. Repeated requests coalesce into one.
- States (encoding 0-5):
  - OCIOSO(0): pend_man → DISPARA with fonte_ultima←1, clear pend_man; else pend_per → DISPARA with fonte_ultima←0, clear pend_per. Manual has priority; the other pending flag stays set. A request arriving in the same cycle its flag is consumed is absorbed (not re-pended).
  - DISPARA(1): medir_dht11=1 for exactly this cycle; timeout counter←0 → AGUARDA.
  - AGUARDA(2): counter increments each cycle. pronto_medida=1 → SUCESSO. Else counter==TIMEOUT-1 → FALHA. If both occur in the same cycle, SUCESSO wins.
  - SUCESSO(3): pronto=1 for one cycle; erro_timeout←0 → INTERVALO.
  - FALHA(4): reset_interface=1 for one cycle; erro_timeout←1; contagem_falhas +1, saturating at 255 → INTERVALO.
  - INTERVALO(5): count INTERVALO_MIN cycles, then → OCIOSO. Requests still latch here.
- Trigger spacing: pronto rises exactly 1 cycle after pronto_medida. Minimum spacing between two medir_dht11 pulses is INTERVALO_MIN+4 cycles.
- pronto_medida outside AGUARDA is ignored.
- Unused encodings 6-7 → OCIOSO.

Optional Feature:
DHT11_SCHED_RETRY_EN
- Defined:
  - FALHA still pulses reset_interface and increments contagem_falhas.
  - While attempts used < MAX_TENTATIVAS, FALHA goes to INTERVALO and then directly to DISPARA, same fonte_ultima. Pending flags are not consumed.
  - erro_timeout is set only when the final attempt times out.
  - Attempt counter clears on SUCESSO or on the final failure.
- Undefined: behaviour exactly as above; MAX_TENTATIVAS ignored.

Test Plan:
Bench parameters: PERIODO=20, INTERVALO_MIN=5, TIMEOUT=8.
- Periodic: reset released, habilita=1, interface answers pronto_medida 3 cycles after trigger → medir_dht11 pulses every 20 cycles; pronto 1 cycle after each pronto_medida; fonte_ultima=0.
- Priority: medir_manual and the periodic expiry pending together in OCIOSO → manual served first (fonte_ultima=1); periodic served next, ≥9 cycles after the first trigger.
- Timeout: no pronto_medida → reset_interface pulses 9 cycles after medir_dht11; erro_timeout=1; contagem_falhas=1. Next successful transaction clears erro_timeout.
- Race: pronto_medida arrives on the cycle the counter reaches 7 → pronto=1, no reset_interface, erro_timeout stays 0.
- Saturation / reset mid-operation: 260 forced timeouts → contagem_falhas=255. Async reset asserted in AGUARDA → all outputs 0 immediately, db_estado=0.
- Retry (macro defined, MAX_TENTATIVAS=3): interface silent → 4 medir_dht11 pulses and 4 reset_interface pulses; erro_timeout rises only after the 4th; contagem_falhas=4.

Source files
------------

// File: rtl/dht11_scheduler.sv
// Arbitrates periodic/manual DHT11 triggers, enforces the sensor rest interval and watchdogs each transaction.
// Optional DHT11_SCHED_RETRY_EN: re-triggers a timed-out transaction up to MAX_TENTATIVAS times before flagging an error.
module dht11_scheduler #(
    parameter int PERIODO        = 100000000,
    parameter int INTERVALO_MIN  = 50000000,
    parameter int TIMEOUT        = 25000000,
    parameter int MAX_TENTATIVAS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       medir_manual,
    input  logic       pronto_medida,
    output logic       medir_dht11,
    output logic       reset_interface,
    output logic       ocupado,
    output logic       pronto,
    output logic       erro_timeout,
    output logic [7:0] contagem_falhas,
    output logic       fonte_ultima,
    output logic [2:0] db_estado
);

    localparam int CNT_MAX = (TIMEOUT > INTERVALO_MIN) ? TIMEOUT : INTERVALO_MIN;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(PERIODO + 1);
    localparam logic [CW-1:0] TIMEOUT_FIM   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] INTERVALO_FIM = CW'(INTERVALO_MIN - 1);
    localparam logic [PW-1:0] PERIODO_FIM   = PW'(PERIODO - 1);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        DISPARA   = 3'd1,
        AGUARDA   = 3'd2,
        SUCESSO   = 3'd3,
        FALHA     = 3'd4,
        INTERVALO = 3'd5
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [PW-1:0] per_q, per_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_man_q, pend_man_d;
    logic          pend_per_q, pend_per_d;
    logic          fonte_q, fonte_d;
    logic          erro_q, erro_d;
    logic [7:0]    falhas_q, falhas_d;
    logic          expira;
    logic          consome_man, consome_per;

`ifdef DHT11_SCHED_RETRY_EN
    localparam int TW = (MAX_TENTATIVAS > 0) ? $clog2(MAX_TENTATIVAS + 1) : 1;
    logic [TW-1:0] tent_q, tent_d;
    logic          retry_q, retry_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tent_q  <= '0;
            retry_q <= 1'b0;
        end else begin
            tent_q  <= tent_d;
            retry_q <= retry_d;
        end
    end
`else
    localparam int unused_max_tentativas = MAX_TENTATIVAS;
`endif

    // Free-running period timer, independent of the transaction FSM
    assign expira = habilita && (per_q == PERIODO_FIM);
    assign per_d  = (!habilita || expira) ? '0 : per_q + 1'b1;

    // A flag consumed this cycle swallows any request arriving in the same cycle
    assign consome_man = (estado_q == OCIOSO) && pend_man_q;
    assign consome_per = (estado_q == OCIOSO) && !pend_man_q && pend_per_q;
    assign pend_man_d  = consome_man ? 1'b0 : (pend_man_q | medir_manual);
    assign pend_per_d  = consome_per ? 1'b0 : (pend_per_q | expira);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            per_q      <= '0;
            cnt_q      <= '0;
            pend_man_q <= 1'b0;
            pend_per_q <= 1'b0;
            fonte_q    <= 1'b0;
            erro_q     <= 1'b0;
            falhas_q   <= '0;
        end else begin
            estado_q   <= estado_d;
            per_q      <= per_d;
            cnt_q      <= cnt_d;
            pend_man_q <= pend_man_d;
            pend_per_q <= pend_per_d;
            fonte_q    <= fonte_d;
            erro_q     <= erro_d;
            falhas_q   <= falhas_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        fonte_d  = fonte_q;
        erro_d   = erro_q;
        falhas_d = falhas_q;
`ifdef DHT11_SCHED_RETRY_EN
        tent_d   = tent_q;
        retry_d  = retry_q;
`endif
        case (estado_q)
            OCIOSO: begin
                if (pend_man_q) begin
                    estado_d = DISPARA;
                    fonte_d  = 1'b1;
                end else if (pend_per_q) begin
                    estado_d = DISPARA;
                    fonte_d  = 1'b0;
                end
            end
            DISPARA: begin
                cnt_d    = '0;
                estado_d = AGUARDA;
            end
            AGUARDA: begin
                // Completion beats timeout when both land on the same cycle
                if (pronto_medida) begin
                    estado_d = SUCESSO;
                end else if (cnt_q == TIMEOUT_FIM) begin
                    estado_d = FALHA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SUCESSO: begin
                erro_d   = 1'b0;
                cnt_d    = '0;
                estado_d = INTERVALO;
`ifdef DHT11_SCHED_RETRY_EN
                tent_d   = '0;
`endif
            end
            FALHA: begin
                if (falhas_q != 8'hFF) falhas_d = falhas_q + 8'd1;
                cnt_d    = '0;
                estado_d = INTERVALO;
`ifdef DHT11_SCHED_RETRY_EN
                if (tent_q < TW'(MAX_TENTATIVAS)) begin
                    tent_d  = tent_q + 1'b1;
                    retry_d = 1'b1;
                end else begin
                    tent_d  = '0;
                    erro_d  = 1'b1;
                end
`else
                erro_d   = 1'b1;
`endif
            end
            INTERVALO: begin
                if (cnt_q == INTERVALO_FIM) begin
                    cnt_d    = '0;
                    estado_d = OCIOSO;
`ifdef DHT11_SCHED_RETRY_EN
                    if (retry_q) begin
                        estado_d = DISPARA;
                        retry_d  = 1'b0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    assign medir_dht11     = (estado_q == DISPARA);
    assign reset_interface = (estado_q == FALHA);
    assign pronto          = (estado_q == SUCESSO);
    assign ocupado         = (estado_q != OCIOSO);
    assign erro_timeout    = erro_q;
    assign contagem_falhas = falhas_q;
    assign fonte_ultima    = fonte_q;
    assign db_estado       = estado_q;

endmodule

// File: tb/tb_dht11_scheduler.sv
// Directed bench for dht11_scheduler with PERIODO=20, INTERVALO_MIN=5, TIMEOUT=8.
module tb_dht11_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       habilita = 1'b0;
    logic       medir_manual = 1'b0;
    logic       pronto_medida = 1'b0;
    logic       medir_dht11;
    logic       reset_interface;
    logic       ocupado;
    logic       pronto;
    logic       erro_timeout;
    logic [7:0] contagem_falhas;
    logic       fonte_ultima;
    logic [2:0] db_estado;

    int errs = 0;
    int checks = 0;

    dht11_scheduler #(
        .PERIODO(20), .INTERVALO_MIN(5), .TIMEOUT(8), .MAX_TENTATIVAS(3)
    ) dut (
        .clock(clock), .reset(reset), .habilita(habilita),
        .medir_manual(medir_manual), .pronto_medida(pronto_medida),
        .medir_dht11(medir_dht11), .reset_interface(reset_interface),
        .ocupado(ocupado), .pronto(pronto), .erro_timeout(erro_timeout),
        .contagem_falhas(contagem_falhas), .fonte_ultima(fonte_ultima),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    logic [16:0] got;
    assign got = {medir_dht11, reset_interface, ocupado, pronto, erro_timeout,
                  contagem_falhas, fonte_ultima, db_estado};

    typedef struct {
        logic       hab, man, pm;
        logic [2:0] est;
        logic       fonte, erro;
        logic [7:0] falhas;
    } vec_t;
    vec_t vecs[$];

    int trig_q[$], fonte_q[$], pronto_q[$], rst_q[$];

    task automatic chk(input string name, input int g, input int e);
        checks++;
        if (g !== e) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, g, e);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [16:0] exp_pack(input vec_t v);
        return {v.est == 3'd1, v.est == 3'd4, v.est != 3'd0, v.est == 3'd3,
                v.erro, v.falhas, v.fonte, v.est};
    endfunction

    task automatic add(input logic hab, input logic man, input logic pm, input int est,
                       input logic fonte, input logic erro, input int falhas, input int n);
        vec_t v;
        v.hab = hab; v.man = man; v.pm = pm; v.est = 3'(est);
        v.fonte = fonte; v.erro = erro; v.falhas = 8'(falhas);
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        habilita = 1'b0;
        medir_manual = 1'b0;
        pronto_medida = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Periodic timer on; interface answers pm_delay cycles after each trigger (0 = never)
    task automatic run_seq(input int ncyc, input int man_at, input int pm_delay);
        int last_trig;
        last_trig = -1000;
        trig_q.delete(); fonte_q.delete(); pronto_q.delete(); rst_q.delete();
        habilita = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clock);
            medir_manual = (n == man_at);
            pronto_medida = 1'b0;
            if (medir_dht11) begin
                last_trig = n;
                trig_q.push_back(n);
                fonte_q.push_back(int'(fonte_ultima));
            end
            if (pronto) pronto_q.push_back(n);
            if (reset_interface) rst_q.push_back(n);
            if (pm_delay > 0 && n == last_trig + pm_delay) pronto_medida = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrst;
        int n_medir;
        int erro_at4;

        // Manual-only walk: success, timeout, then a completion racing the timeout
        add(0,1,0, 0,0,0,0, 1);
        add(0,0,0, 1,1,0,0, 1);
        add(0,0,0, 2,1,0,0, 2);
        add(0,0,1, 3,1,0,0, 1);
        add(0,1,1, 5,1,0,0, 1);
        add(0,0,0, 5,1,0,0, 4);
        add(0,0,0, 0,1,0,0, 1);
        add(0,0,0, 1,1,0,0, 1);
        add(0,0,0, 2,1,0,0, 8);
        add(0,0,0, 4,1,0,0, 1);
        add(0,0,0, 5,1,1,1, 5);
        add(0,1,0, 0,1,1,1, 1);
        add(0,0,0, 1,1,1,1, 1);
        add(0,0,0, 2,1,1,1, 8);
        add(0,0,1, 3,1,1,1, 1);
        add(0,0,0, 5,1,0,1, 5);
        add(0,0,0, 0,1,0,1, 1);

        do_reset();
        chk("reset_state", int'(got), 0);
        foreach (vecs[i]) begin
            habilita = vecs[i].hab;
            medir_manual = vecs[i].man;
            pronto_medida = vecs[i].pm;
            @(negedge clock);
            chk($sformatf("vec%0d", i), int'(got), int'(exp_pack(vecs[i])));
        end

        // Periodic triggers every 20 cycles, pronto one cycle after pronto_medida
        do_reset();
        run_seq(70, -1, 3);
        chk("per_trig0", at(trig_q, 0), 21);
        chk("per_trig1", at(trig_q, 1), 41);
        chk("per_trig2", at(trig_q, 2), 61);
        chk("per_fonte0", at(fonte_q, 0), 0);
        chk("per_fonte2", at(fonte_q, 2), 0);
        chk("per_pronto0", at(pronto_q, 0), 25);
        chk("per_pronto2", at(pronto_q, 2), 65);

        // Manual and periodic pending together: manual first, periodic at minimum spacing
        do_reset();
        run_seq(35, 19, 1);
        chk("prio_trig0", at(trig_q, 0), 21);
        chk("prio_fonte0", at(fonte_q, 0), 1);
        chk("prio_trig1", at(trig_q, 1), 30);
        chk("prio_fonte1", at(fonte_q, 1), 0);
        chk("prio_pronto0", at(pronto_q, 0), 23);

        // Silent interface: reset_interface 9 cycles after the trigger
        do_reset();
        run_seq(40, -1, 0);
        chk("to_trig", at(trig_q, 0), 21);
        chk("to_rst_if", at(rst_q, 0), 30);
        chk("to_nrst", rst_q.size(), 1);
        chk("to_erro", int'(erro_timeout), 1);
        chk("to_falhas", int'(contagem_falhas), 1);

        // Saturation of the failure counter
        do_reset();
        medir_manual = 1'b1;
        nrst = 0;
        for (int n = 0; n < 5000 && nrst < 260; n++) begin
            @(negedge clock);
            if (reset_interface) nrst++;
        end
        medir_manual = 1'b0;
        chk("sat_nrst", nrst, 260);
        repeat (2) @(negedge clock);
        chk("sat_falhas", int'(contagem_falhas), 255);
        chk("sat_erro", int'(erro_timeout), 1);

        // Async reset while waiting on the interface
        for (int n = 0; n < 40 && db_estado != 3'd2; n++) @(negedge clock);
        chk("mid_reach_aguarda", int'(db_estado), 2);
        #1 reset = 1'b1;
        #1 chk("mid_async_rst", int'(got), 0);
        @(negedge clock);
        reset = 1'b0;

`ifdef DHT11_SCHED_RETRY_EN
        do_reset();
        medir_manual = 1'b1;
        @(negedge clock);
        medir_manual = 1'b0;
        nrst = 0;
        n_medir = 0;
        erro_at4 = -1;
        for (int n = 0; n < 120; n++) begin
            @(negedge clock);
            if (medir_dht11) n_medir++;
            if (reset_interface) begin
                nrst++;
                if (nrst == 4) erro_at4 = int'(erro_timeout);
            end
        end
        chk("retry_medir", n_medir, 4);
        chk("retry_rst_if", nrst, 4);
        chk("retry_erro_at4", erro_at4, 0);
        chk("retry_erro_end", int'(erro_timeout), 1);
        chk("retry_falhas", int'(contagem_falhas), 4);
`else
        n_medir = 0;
        erro_at4 = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
